// File: rtl/eq_frame_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : eq_frame_arbiter
// Description : Two-requester AXI-Stream frame arbiter feeding an equalizer.
//               Grants whole frames round-robin through one output register.
// Revision    : 1.0 - initial release
// ============================================================================
module eq_frame_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int MAX_FRAME  = 256
) (
    input  logic                      axis_aclk,
    input  logic                      axis_aresetn,

    input  logic                      s00_axis_tvalid,
    output logic                      s00_axis_tready,
    input  logic                      s00_axis_tlast,
    input  logic [DATA_WIDTH-1:0]     s00_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0]   s00_axis_tstrb,

    input  logic                      s01_axis_tvalid,
    output logic                      s01_axis_tready,
    input  logic                      s01_axis_tlast,
    input  logic [DATA_WIDTH-1:0]     s01_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0]   s01_axis_tstrb,

    output logic                      m00_axis_tvalid,
    input  logic                      m00_axis_tready,
    output logic                      m00_axis_tlast,
    output logic [DATA_WIDTH-1:0]     m00_axis_tdata,
    output logic [DATA_WIDTH/8-1:0]   m00_axis_tstrb,
    output logic                      m00_axis_tuser,

    output logic [15:0]               frame_cnt0,
    output logic [15:0]               frame_cnt1,
    output logic                      trunc_err
);

    localparam logic [1:0]  c_st_idle   = 2'd0;
    localparam logic [1:0]  c_st_grant0 = 2'd1;
    localparam logic [1:0]  c_st_grant1 = 2'd2;
    localparam logic [15:0] c_last_beat = 16'(MAX_FRAME - 1);

    logic [1:0]              r_state;
    logic                    r_rr;
    logic [15:0]             r_beat_cnt;
    logic [15:0]             r_frame_cnt0;
    logic [15:0]             r_frame_cnt1;
    logic                    r_trunc_err;

    logic                    r_m_valid;
    logic                    r_m_last;
    logic                    r_m_user;
    logic [DATA_WIDTH-1:0]   r_m_data;
    logic [DATA_WIDTH/8-1:0] r_m_strb;

    logic                    w_gnt0;
    logic                    w_gnt1;
    logic                    w_out_ready;
    logic                    w_acc;
    logic                    w_src_last;
    logic [DATA_WIDTH-1:0]   w_src_data;
    logic [DATA_WIDTH/8-1:0] w_src_strb;
    logic                    w_force;
    logic                    w_frame_end;

    assign w_gnt0      = (r_state == c_st_grant0);
    assign w_gnt1      = (r_state == c_st_grant1);
    // Output register can take a beat when empty or draining this cycle.
    assign w_out_ready = ~r_m_valid | m00_axis_tready;

    assign s00_axis_tready = w_gnt0 & w_out_ready;
    assign s01_axis_tready = w_gnt1 & w_out_ready;

    assign w_acc = (s00_axis_tvalid & s00_axis_tready) |
                   (s01_axis_tvalid & s01_axis_tready);

    always_comb begin
        w_src_last = s00_axis_tlast;
        w_src_data = s00_axis_tdata;
        w_src_strb = s00_axis_tstrb;
        if (w_gnt1) begin
            w_src_last = s01_axis_tlast;
            w_src_data = s01_axis_tdata;
            w_src_strb = s01_axis_tstrb;
        end
    end

    assign w_force     = (r_beat_cnt == c_last_beat);
    assign w_frame_end = w_acc & (w_src_last | w_force);

    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            r_state <= c_st_idle;
            r_rr    <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (s00_axis_tvalid && s01_axis_tvalid)
                        r_state <= r_rr ? c_st_grant1 : c_st_grant0;
                    else if (s00_axis_tvalid)
                        r_state <= c_st_grant0;
                    else if (s01_axis_tvalid)
                        r_state <= c_st_grant1;
                end
                c_st_grant0: begin
                    if (w_frame_end) begin
                        r_state <= c_st_idle;
                        r_rr    <= 1'b1;
                    end
                end
                c_st_grant1: begin
                    if (w_frame_end) begin
                        r_state <= c_st_idle;
                        r_rr    <= 1'b0;
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            r_beat_cnt   <= 16'd0;
            r_frame_cnt0 <= 16'd0;
            r_frame_cnt1 <= 16'd0;
            r_trunc_err  <= 1'b0;
        end else begin
            if (w_frame_end)
                r_beat_cnt <= 16'd0;
            else if (w_acc)
                r_beat_cnt <= r_beat_cnt + 16'd1;

            if (w_frame_end && w_gnt0)
                r_frame_cnt0 <= r_frame_cnt0 + 16'd1;
            if (w_frame_end && w_gnt1)
                r_frame_cnt1 <= r_frame_cnt1 + 16'd1;

            // A real tlast on the limit beat is a normal end, not a truncation.
            if (w_frame_end && w_force && !w_src_last)
                r_trunc_err <= 1'b1;
        end
    end

    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            r_m_valid <= 1'b0;
            r_m_last  <= 1'b0;
            r_m_user  <= 1'b0;
            r_m_data  <= '0;
            r_m_strb  <= '0;
        end else if (w_acc) begin
            r_m_valid <= 1'b1;
            r_m_last  <= w_src_last | w_force;
            r_m_user  <= w_gnt1;
            r_m_data  <= w_src_data;
            r_m_strb  <= w_src_strb;
        end else if (m00_axis_tready) begin
            r_m_valid <= 1'b0;
        end
    end

    assign m00_axis_tvalid = r_m_valid;
    assign m00_axis_tlast  = r_m_last;
    assign m00_axis_tuser  = r_m_user;
    assign m00_axis_tdata  = r_m_data;
    assign m00_axis_tstrb  = r_m_strb;
    assign frame_cnt0      = r_frame_cnt0;
    assign frame_cnt1      = r_frame_cnt1;
    assign trunc_err       = r_trunc_err;

endmodule
`default_nettype wire

// File: tb/tb_eq_frame_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_eq_frame_arbiter
// Description : Directed self-checking bench for eq_frame_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_eq_frame_arbiter;

    logic clk;
    logic rst_n;

    // Instance with default frame limit
    logic        a_s00_tvalid, a_s00_tready, a_s00_tlast;
    logic [31:0] a_s00_tdata;
    logic [3:0]  a_s00_tstrb;
    logic        a_s01_tvalid, a_s01_tready, a_s01_tlast;
    logic [31:0] a_s01_tdata;
    logic [3:0]  a_s01_tstrb;
    logic        a_m_valid, a_m_ready, a_m_last, a_m_user;
    logic [31:0] a_m_data;
    logic [3:0]  a_m_strb;
    logic [15:0] a_cnt0, a_cnt1;
    logic        a_trunc;

    // Instance with a 4-beat frame limit
    logic        b_s00_tvalid, b_s00_tready, b_s00_tlast;
    logic [31:0] b_s00_tdata;
    logic [3:0]  b_s00_tstrb;
    logic        b_s01_tvalid, b_s01_tready, b_s01_tlast;
    logic [31:0] b_s01_tdata;
    logic [3:0]  b_s01_tstrb;
    logic        b_m_valid, b_m_ready, b_m_last, b_m_user;
    logic [31:0] b_m_data;
    logic [3:0]  b_m_strb;
    logic [15:0] b_cnt0, b_cnt1;
    logic        b_trunc;

    eq_frame_arbiter #(.DATA_WIDTH(32), .MAX_FRAME(256)) dut (
        .axis_aclk(clk), .axis_aresetn(rst_n),
        .s00_axis_tvalid(a_s00_tvalid), .s00_axis_tready(a_s00_tready),
        .s00_axis_tlast(a_s00_tlast), .s00_axis_tdata(a_s00_tdata),
        .s00_axis_tstrb(a_s00_tstrb),
        .s01_axis_tvalid(a_s01_tvalid), .s01_axis_tready(a_s01_tready),
        .s01_axis_tlast(a_s01_tlast), .s01_axis_tdata(a_s01_tdata),
        .s01_axis_tstrb(a_s01_tstrb),
        .m00_axis_tvalid(a_m_valid), .m00_axis_tready(a_m_ready),
        .m00_axis_tlast(a_m_last), .m00_axis_tdata(a_m_data),
        .m00_axis_tstrb(a_m_strb), .m00_axis_tuser(a_m_user),
        .frame_cnt0(a_cnt0), .frame_cnt1(a_cnt1), .trunc_err(a_trunc)
    );

    eq_frame_arbiter #(.DATA_WIDTH(32), .MAX_FRAME(4)) dut4 (
        .axis_aclk(clk), .axis_aresetn(rst_n),
        .s00_axis_tvalid(b_s00_tvalid), .s00_axis_tready(b_s00_tready),
        .s00_axis_tlast(b_s00_tlast), .s00_axis_tdata(b_s00_tdata),
        .s00_axis_tstrb(b_s00_tstrb),
        .s01_axis_tvalid(b_s01_tvalid), .s01_axis_tready(b_s01_tready),
        .s01_axis_tlast(b_s01_tlast), .s01_axis_tdata(b_s01_tdata),
        .s01_axis_tstrb(b_s01_tstrb),
        .m00_axis_tvalid(b_m_valid), .m00_axis_tready(b_m_ready),
        .m00_axis_tlast(b_m_last), .m00_axis_tdata(b_m_data),
        .m00_axis_tstrb(b_m_strb), .m00_axis_tuser(b_m_user),
        .frame_cnt0(b_cnt0), .frame_cnt1(b_cnt1), .trunc_err(b_trunc)
    );

    typedef struct {
        logic [31:0] data;
        logic [3:0]  strb;
        logic        last;
        logic        user;
        int          cyc;
    } beat_t;

    beat_t q0[$], q1[$], q4[$];
    beat_t exp_a[$], cap_a[$], exp_b[$], cap_b[$];

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (rst_n && a_m_valid && a_m_ready)
            cap_a.push_back('{a_m_data, a_m_strb, a_m_last, a_m_user, cyc});
        if (rst_n && b_m_valid && b_m_ready)
            cap_b.push_back('{b_m_data, b_m_strb, b_m_last, b_m_user, cyc});
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] strb_of(input int i);
        logic [3:0] s;
        s = 4'hF;
        return s >> (i % 4);
    endfunction

    // src: 0 = main s00, 1 = main s01, 2 = limited instance s01
    task automatic src_frame(input int src, input int n, input logic [31:0] base);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b = '{base + 32'(i), strb_of(i), (i == n - 1), 1'b0, 0};
            if (src == 0) q0.push_back(b);
            else if (src == 1) q1.push_back(b);
            else q4.push_back(b);
        end
    endtask

    task automatic exp_frame(input bit to_b, input logic user, input int n,
                             input logic [31:0] base, input int force_len);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b = '{base + 32'(i), strb_of(i),
                  (i == n - 1) || (force_len != 0 && (i % force_len) == force_len - 1),
                  user, 0};
            if (to_b) exp_b.push_back(b);
            else exp_a.push_back(b);
        end
    endtask

    task automatic cmp_stream(input bit to_b, input bit check_gap, input string tag);
        int ne, nc;
        beat_t e, c, cp;
        ne = to_b ? exp_b.size() : exp_a.size();
        nc = to_b ? cap_b.size() : cap_a.size();
        chk({tag, "_count"}, 32'(nc), 32'(ne));
        for (int i = 0; i < ne && i < nc; i++) begin
            e = to_b ? exp_b[i] : exp_a[i];
            c = to_b ? cap_b[i] : cap_a[i];
            chk($sformatf("%s_data[%0d]", tag, i), c.data, e.data);
            chk($sformatf("%s_strb[%0d]", tag, i), {28'd0, c.strb}, {28'd0, e.strb});
            chk($sformatf("%s_last[%0d]", tag, i), {31'd0, c.last}, {31'd0, e.last});
            chk($sformatf("%s_user[%0d]", tag, i), {31'd0, c.user}, {31'd0, e.user});
            if (check_gap && i > 0) begin
                cp = to_b ? cap_b[i-1] : cap_a[i-1];
                e  = to_b ? exp_b[i-1] : exp_a[i-1];
                chk($sformatf("%s_gap[%0d]", tag, i), 32'(c.cyc - cp.cyc), e.last ? 32'd2 : 32'd1);
            end
        end
    endtask

    // Drives the main instance from q0/q1 until drained. Called and returns at a negedge.
    task automatic pump(input bit toggle, input int stop0, input int budget);
        bit          done, stalled, acc0, acc1;
        int          nacc0;
        logic [31:0] sv_data;
        logic [3:0]  sv_strb;
        logic        sv_last, sv_user;
        done = 0; stalled = 0; nacc0 = 0;
        for (int c = 0; c < budget && !done; c++) begin
            if (stalled) begin
                chk("stall_valid", {31'd0, a_m_valid}, 32'd1);
                chk("stall_data", a_m_data, sv_data);
                chk("stall_strb", {28'd0, a_m_strb}, {28'd0, sv_strb});
                chk("stall_last", {31'd0, a_m_last}, {31'd0, sv_last});
                chk("stall_user", {31'd0, a_m_user}, {31'd0, sv_user});
            end
            if (q0.size() == 0 && q1.size() == 0 && !a_m_valid) begin
                a_s00_tvalid = 1'b0;
                a_s01_tvalid = 1'b0;
                done = 1;
            end else begin
                a_s00_tvalid = (q0.size() > 0);
                if (q0.size() > 0) {a_s00_tdata, a_s00_tstrb, a_s00_tlast} = {q0[0].data, q0[0].strb, q0[0].last};
                a_s01_tvalid = (q1.size() > 0);
                if (q1.size() > 0) {a_s01_tdata, a_s01_tstrb, a_s01_tlast} = {q1[0].data, q1[0].strb, q1[0].last};
                a_m_ready = toggle ? (c % 2 == 1) : 1'b1;
                #1;
                chk("tready_exclusive", {31'd0, a_s00_tready & a_s01_tready}, 32'd0);
                acc0 = a_s00_tvalid & a_s00_tready;
                acc1 = a_s01_tvalid & a_s01_tready;
                stalled = a_m_valid & ~a_m_ready;
                {sv_data, sv_strb, sv_last, sv_user} = {a_m_data, a_m_strb, a_m_last, a_m_user};
                @(posedge clk);
                if (acc0) begin void'(q0.pop_front()); nacc0++; end
                if (acc1) void'(q1.pop_front());
                @(negedge clk);
                if (stop0 != 0 && nacc0 == stop0) done = 1;
            end
        end
        chk("pump_done", {31'd0, done}, 32'd1);
    endtask

    task automatic pump4(input int budget);
        bit done, acc;
        done = 0;
        b_m_ready = 1'b1;
        for (int c = 0; c < budget && !done; c++) begin
            if (q4.size() == 0 && !b_m_valid) begin
                b_s01_tvalid = 1'b0;
                done = 1;
            end else begin
                b_s01_tvalid = (q4.size() > 0);
                if (q4.size() > 0) {b_s01_tdata, b_s01_tstrb, b_s01_tlast} = {q4[0].data, q4[0].strb, q4[0].last};
                #1;
                chk("b_s00_tready_idle", {31'd0, b_s00_tready}, 32'd0);
                acc = b_s01_tvalid & b_s01_tready;
                @(posedge clk);
                if (acc) void'(q4.pop_front());
                @(negedge clk);
            end
        end
        chk("pump4_done", {31'd0, done}, 32'd1);
    endtask

    task automatic chk_reset_main(input string tag);
        chk({tag, "_s00_tready"}, {31'd0, a_s00_tready}, 32'd0);
        chk({tag, "_s01_tready"}, {31'd0, a_s01_tready}, 32'd0);
        chk({tag, "_m_valid"}, {31'd0, a_m_valid}, 32'd0);
        chk({tag, "_m_last"}, {31'd0, a_m_last}, 32'd0);
        chk({tag, "_m_user"}, {31'd0, a_m_user}, 32'd0);
        chk({tag, "_m_data"}, a_m_data, 32'd0);
        chk({tag, "_m_strb"}, {28'd0, a_m_strb}, 32'd0);
        chk({tag, "_cnt0"}, {16'd0, a_cnt0}, 32'd0);
        chk({tag, "_cnt1"}, {16'd0, a_cnt1}, 32'd0);
        chk({tag, "_trunc"}, {31'd0, a_trunc}, 32'd0);
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [31:0] r030_words [8];

    initial begin
        rst_n = 1'b0;
        {a_s00_tvalid, a_s00_tlast, a_s00_tdata, a_s00_tstrb} = '0;
        {a_s01_tvalid, a_s01_tlast, a_s01_tdata, a_s01_tstrb} = '0;
        {b_s00_tvalid, b_s00_tlast, b_s00_tdata, b_s00_tstrb} = '0;
        {b_s01_tvalid, b_s01_tlast, b_s01_tdata, b_s01_tstrb} = '0;
        a_m_ready = 1'b1;
        b_m_ready = 1'b1;
        r030_words = '{32'h3000, 32'hB000, 32'h2000, 32'h8000,
                       32'hA000, 32'h3400, 32'hC200, 32'hAA00};

        repeat (3) @(negedge clk);
        chk_reset_main("rst0");
        chk("rst0_b_trunc", {31'd0, b_trunc}, 32'd0);
        chk("rst0_b_cnt1", {16'd0, b_cnt1}, 32'd0);
        rst_n = 1'b1;

        // Single 8-beat frame from s00
        for (int i = 0; i < 8; i++) begin
            q0.push_back('{r030_words[i], 4'hF, (i == 7), 1'b0, 0});
            exp_a.push_back('{r030_words[i], 4'hF, (i == 7), 1'b0, 0});
        end
        pump(1'b0, 0, 200);
        cmp_stream(1'b0, 1'b1, "single");
        chk("single_cnt0", {16'd0, a_cnt0}, 32'd1);
        chk("single_cnt1", {16'd0, a_cnt1}, 32'd0);
        chk("single_trunc", {31'd0, a_trunc}, 32'd0);

        // Both requesters contending straight out of reset
        reset_pulse();
        exp_a.delete(); cap_a.delete();
        src_frame(0, 4, 32'h1000_0000); src_frame(0, 4, 32'h1000_0010);
        src_frame(1, 4, 32'h2000_0000); src_frame(1, 4, 32'h2000_0010);
        exp_frame(1'b0, 1'b0, 4, 32'h1000_0000, 0);
        exp_frame(1'b0, 1'b1, 4, 32'h2000_0000, 0);
        exp_frame(1'b0, 1'b0, 4, 32'h1000_0010, 0);
        exp_frame(1'b0, 1'b1, 4, 32'h2000_0010, 0);
        pump(1'b0, 0, 300);
        cmp_stream(1'b0, 1'b1, "rr");
        chk("rr_cnt0", {16'd0, a_cnt0}, 32'd2);
        chk("rr_cnt1", {16'd0, a_cnt1}, 32'd2);

        // Back-pressure toggling every cycle
        exp_a.delete(); cap_a.delete();
        src_frame(0, 6, 32'h3000_0000);
        exp_frame(1'b0, 1'b0, 6, 32'h3000_0000, 0);
        pump(1'b1, 0, 300);
        cmp_stream(1'b0, 1'b0, "bp");
        chk("bp_cnt0", {16'd0, a_cnt0}, 32'd3);
        a_m_ready = 1'b1;

        // Limited instance: tlast exactly on the limit beat is a normal end
        src_frame(2, 4, 32'h4000_0000);
        exp_frame(1'b1, 1'b1, 4, 32'h4000_0000, 4);
        pump4(200);
        chk("limit_exact_trunc", {31'd0, b_trunc}, 32'd0);
        chk("limit_exact_cnt1", {16'd0, b_cnt1}, 32'd1);

        // Limited instance: 6-beat frame splits into 4 + 2
        src_frame(2, 6, 32'h4100_0000);
        exp_frame(1'b1, 1'b1, 6, 32'h4100_0000, 4);
        pump4(200);
        cmp_stream(1'b1, 1'b0, "limit");
        chk("limit_trunc", {31'd0, b_trunc}, 32'd1);
        chk("limit_cnt1", {16'd0, b_cnt1}, 32'd3);
        chk("limit_cnt0", {16'd0, b_cnt0}, 32'd0);

        // Reset in the middle of a frame
        src_frame(0, 8, 32'h5000_0000);
        pump(1'b0, 3, 100);
        a_s00_tvalid = 1'b0;
        chk("pre_rst_m_valid", {31'd0, a_m_valid}, 32'd1);
        chk("pre_rst_m_data", a_m_data, 32'h5000_0002);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_main("midrst");
        q0.delete(); q1.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_a.delete(); cap_a.delete();
        src_frame(0, 8, 32'h6000_0000);
        exp_frame(1'b0, 1'b0, 8, 32'h6000_0000, 0);
        pump(1'b0, 0, 200);
        cmp_stream(1'b0, 1'b0, "post_rst");
        chk("post_rst_cnt0", {16'd0, a_cnt0}, 32'd1);

        // Frame counter wrap from 0xFFFF
        force dut.r_frame_cnt0 = 16'hFFFF;
        @(negedge clk);
        release dut.r_frame_cnt0;
        @(negedge clk);
        exp_a.delete(); cap_a.delete();
        src_frame(0, 1, 32'h7000_0000);
        exp_frame(1'b0, 1'b0, 1, 32'h7000_0000, 0);
        pump(1'b0, 0, 100);
        cmp_stream(1'b0, 1'b0, "wrap");
        chk("wrap_cnt0", {16'd0, a_cnt0}, 32'd0);
        chk("wrap_cnt1", {16'd0, a_cnt1}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
